// File: rtl/key_pkg.sv
// Shared constants for the key input path: click FSM state encoding and the
// default timing windows used by key_filter and key_click_decoder.
package key_pkg;

  // Click burst state: no burst, one press seen, two presses seen.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2
  } click_state_t;

  // Inter-press window: 500 ms at 50 MHz, and a short value for simulation.
  localparam logic [24:0] CNT_WIN_500MS = 25'd24_999_999;
  localparam int          CNT_WIN_SIM   = 20;

  // key_filter debounce defaults: 20 ms at 50 MHz, and a short value for simulation.
  localparam logic [19:0] CNT_MAX_20MS  = 20'd999_999;
  localparam int          CNT_MAX_SIM   = 10;

  // Number of presses counted in the open burst for a given state.
  function automatic logic [1:0] state_num(input click_state_t s);
    case (s)
      WAIT1:   state_num = 2'd1;
      WAIT2:   state_num = 2'd2;
      default: state_num = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/key_click_decoder.sv
// Classifies bursts of debounced key presses as single, double or triple
// clicks using a programmable inter-press window. One registered one-cycle
// pulse per burst, plus a registered view of the burst in progress.
//
// Handshake: key_flag is a one-cycle strobe with no back-pressure; every
// cycle it is high counts as one press. The click pulses are one-cycle
// strobes with no ready; downstream must sample them on the cycle they occur.
module key_click_decoder
  import key_pkg::*;
#(
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] CNT_WIN = CNT_W'(CNT_WIN_500MS)
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_flag,
  output logic       single_click,
  output logic       double_click,
  output logic       triple_click,
  output logic       click_busy,
  output logic [1:0] click_num
);

  click_state_t     state, state_next;
  logic [CNT_W-1:0] win_cnt, win_cnt_next;
  logic             single_next, double_next, triple_next;

  // State, window counter and all outputs registered together; reset drops any open burst.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      win_cnt      <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      triple_click <= 1'b0;
      click_busy   <= 1'b0;
      click_num    <= 2'd0;
    end else begin
      state        <= state_next;
      win_cnt      <= win_cnt_next;
      single_click <= single_next;
      double_click <= double_next;
      triple_click <= triple_next;
      click_busy   <= (state_next != IDLE);
      click_num    <= state_num(state_next);
    end
  end

  // Next state, window count and click pulses. A press on the window's last
  // cycle takes priority over the timeout, so it still extends the burst.
  always_comb begin
    state_next   = state;
    win_cnt_next = win_cnt;
    single_next  = 1'b0;
    double_next  = 1'b0;
    triple_next  = 1'b0;
    case (state)
      IDLE: begin
        win_cnt_next = '0;
        if (key_flag) begin
          state_next = WAIT1;
        end
      end
      WAIT1: begin
        if (key_flag) begin
          state_next   = WAIT2;
          win_cnt_next = '0;
        end else if (win_cnt == CNT_WIN) begin
          single_next  = 1'b1;
          state_next   = IDLE;
          win_cnt_next = '0;
        end else begin
          win_cnt_next = win_cnt + CNT_W'(1);
        end
      end
      WAIT2: begin
        if (key_flag) begin
          triple_next  = 1'b1;
          state_next   = IDLE;
          win_cnt_next = '0;
        end else if (win_cnt == CNT_WIN) begin
          double_next  = 1'b1;
          state_next   = IDLE;
          win_cnt_next = '0;
        end else begin
          win_cnt_next = win_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        win_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder with a 20-cycle window. Each scenario
// lists press edges (t = 0 is the first press edge) and the hand-computed
// edges and kinds of the click pulses; every cycle after each edge the
// pulses, click_busy and click_num are compared.
module tb_key_click_decoder;
  import key_pkg::*;

  localparam logic [2:0] P_NONE   = 3'b000;
  localparam logic [2:0] P_SINGLE = 3'b001;
  localparam logic [2:0] P_DOUBLE = 3'b010;
  localparam logic [2:0] P_TRIPLE = 3'b100;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_flag = 1'b0;
  logic       single_click, double_click, triple_click, click_busy;
  logic [1:0] click_num;

  int total = 0;
  int bad   = 0;

  key_click_decoder #(
    .CNT_W   (25),
    .CNT_WIN (25'(CNT_WIN_SIM))
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_flag     (key_flag),
    .single_click (single_click),
    .double_click (double_click),
    .triple_click (triple_click),
    .click_busy   (click_busy),
    .click_num    (click_num)
  );

  // Clock: 10 ns period.
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_cycle(input string name, input int t,
                             input logic [2:0] exp_p, input logic [1:0] exp_num);
    check($sformatf("%s t=%0d pulses", name, t),
          {1'b0, triple_click, double_click, single_click}, {1'b0, exp_p});
    check($sformatf("%s t=%0d busy", name, t),
          {3'b000, click_busy}, {3'b000, (exp_num != 2'd0)});
    check($sformatf("%s t=%0d num", name, t),
          {2'b00, click_num}, {2'b00, exp_num});
  endtask

  // Presses at f0..f3 (-1 = unused); pulse p1 expected right after edge e1,
  // p2 after edge e2 (-1 = none). Expected count = presses since the last pulse.
  task automatic run_scn(input string name, input int f0, input int f1, input int f2,
                         input int f3, input int e1, input logic [2:0] p1,
                         input int e2, input logic [2:0] p2, input int len);
    int         last_end;
    int         n;
    logic [2:0] exp_p;
    last_end = -1;
    for (int t = 0; t <= len; t++) begin
      key_flag = (t == f0 || t == f1 || t == f2 || t == f3);
      @(posedge sys_clk);
      #1;
      if (t == e1 || t == e2) last_end = t;
      n = 0;
      if (f0 >= 0 && f0 <= t && f0 > last_end) n++;
      if (f1 >= 0 && f1 <= t && f1 > last_end) n++;
      if (f2 >= 0 && f2 <= t && f2 > last_end) n++;
      if (f3 >= 0 && f3 <= t && f3 > last_end) n++;
      exp_p = (t == e1) ? p1 : (t == e2) ? p2 : P_NONE;
      check_cycle(name, t, exp_p, 2'(n));
    end
    key_flag = 1'b0;
  endtask

  // Watchdog: all waits are fixed cycle counts, this only guards the overall run.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_num;
    logic [2:0] exp_p;

    // Reset held: everything low.
    repeat (2) @(posedge sys_clk);
    #1;
    check_cycle("reset", 0, P_NONE, 2'd0);
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check_cycle("post_reset", 0, P_NONE, 2'd0);

    run_scn("single",   0, -1, -1, -1, 21, P_SINGLE, -1, P_NONE,   26);
    run_scn("double",   0, 10, -1, -1, 31, P_DOUBLE, -1, P_NONE,   36);
    run_scn("triple",   0,  5, 10, -1, 10, P_TRIPLE, -1, P_NONE,   35);
    run_scn("tie",      0, 21, -1, -1, 42, P_DOUBLE, -1, P_NONE,   46);
    run_scn("late",     0, 22, -1, -1, 21, P_SINGLE, 43, P_SINGLE, 48);
    run_scn("back2back",0,  5, 10, 11, 10, P_TRIPLE, 32, P_SINGLE, 37);

    // Reset mid-burst: press at 0, reset across edges 8..11, new press at 40.
    for (int t = 0; t <= 66; t++) begin
      key_flag = (t == 0 || t == 40);
      if (t == 8) begin
        sys_rst = 1'b1;
        #1;
        check_cycle("rst_async", t, P_NONE, 2'd0);
      end
      if (t == 12) sys_rst = 1'b0;
      @(posedge sys_clk);
      #1;
      exp_num = ((t < 8) || (t >= 40 && t < 61)) ? 2'd1 : 2'd0;
      exp_p   = (t == 61) ? P_SINGLE : P_NONE;
      check_cycle("rst_mid", t, exp_p, exp_num);
    end
    key_flag = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
